// File: rtl/req_arb_pkg.sv
// Shared definitions for the two-master request arbiter and related benches.
package req_arb_pkg;

    localparam int LW_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } arb_state_t;

endpackage

// File: rtl/req_arb_beat_ctr.sv
// Beats-remaining down-counter; last is high while the current beat is the final one.
module req_arb_beat_ctr
    import req_arb_pkg::*;
#(
    parameter int LW = LW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [LW-1:0] load_val,
    input  logic          beat,
    output logic          last
);

    logic [LW-1:0] cnt;

    // Holds at zero so stray beats after the final one cannot wrap the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (beat && (cnt != '0)) begin
            cnt <= cnt - LW'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/req_arb.sv
// Two-master arbiter holding each grant for a whole transaction (request plus all beats).
// Define REQ_ARB_RR_EN for round-robin tie-breaking; otherwise m0 has fixed priority.
//
// state    | meaning
// ST_IDLE  | no grant active; pick a requester
// ST_REQ   | granted master's request presented to the slave
// ST_WDATA | forwarding write beats from the granted master
// ST_RDATA | forwarding read beats to the granted master
module req_arb
    import req_arb_pkg::*;
#(
    parameter int LW = LW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req_valid,
    output logic          m0_req_ready,
    input  logic [LW-1:0] m0_req_len,
    input  logic [3:0]    m0_req_mask,
    input  logic [31:0]   m0_req_addr,
    input  logic          m0_req_we,
    input  logic          m0_write_valid,
    input  logic [31:0]   m0_write_data,
    output logic          m0_read_valid,
    input  logic          m0_read_ack,
    output logic [31:0]   m0_read_data,

    input  logic          m1_req_valid,
    output logic          m1_req_ready,
    input  logic [LW-1:0] m1_req_len,
    input  logic [3:0]    m1_req_mask,
    input  logic [31:0]   m1_req_addr,
    input  logic          m1_req_we,
    input  logic          m1_write_valid,
    input  logic [31:0]   m1_write_data,
    output logic          m1_read_valid,
    input  logic          m1_read_ack,
    output logic [31:0]   m1_read_data,

    output logic          s_req_valid,
    input  logic          s_req_ready,
    output logic [LW-1:0] s_req_len,
    output logic [3:0]    s_req_mask,
    output logic [31:0]   s_req_addr,
    output logic          s_req_we,
    output logic          s_write_valid,
    output logic [31:0]   s_write_data,
    input  logic          s_read_valid,
    output logic          s_read_ack,
    input  logic [31:0]   s_read_data
);

    arb_state_t state, state_nxt;
    logic       grant, grant_nxt;
    logic       last_grant, last_grant_nxt;
    logic       pick;
    logic       ctr_load, ctr_beat, ctr_last;

    logic       g_req_valid, g_write_valid, g_read_ack;

`ifdef REQ_ARB_RR_EN
    // m1 wins when alone, or on a tie when m0 had the previous grant.
    assign pick = m1_req_valid && (!m0_req_valid || !last_grant);
`else
    assign pick = !m0_req_valid;
`endif

    assign g_req_valid   = grant ? m1_req_valid   : m0_req_valid;
    assign g_write_valid = grant ? m1_write_valid : m0_write_valid;
    assign g_read_ack    = grant ? m1_read_ack    : m0_read_ack;

    assign s_req_len    = grant ? m1_req_len    : m0_req_len;
    assign s_req_mask   = grant ? m1_req_mask   : m0_req_mask;
    assign s_req_addr   = grant ? m1_req_addr   : m0_req_addr;
    assign s_req_we     = grant ? m1_req_we     : m0_req_we;
    assign s_write_data = grant ? m1_write_data : m0_write_data;
    assign m0_read_data = s_read_data;
    assign m1_read_data = s_read_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        ctr_load       = 1'b0;
        ctr_beat       = 1'b0;
        s_req_valid    = 1'b0;
        s_write_valid  = 1'b0;
        s_read_ack     = 1'b0;
        m0_req_ready   = 1'b0;
        m1_req_ready   = 1'b0;
        m0_read_valid  = 1'b0;
        m1_read_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m0_req_valid || m1_req_valid) begin
                    grant_nxt      = pick;
                    last_grant_nxt = pick;
                    state_nxt      = ST_REQ;
                end
            end
            ST_REQ: begin
                s_req_valid  = g_req_valid;
                m0_req_ready = s_req_ready && !grant;
                m1_req_ready = s_req_ready && grant;
                // A master withdrawing its request abandons the grant without touching the slave.
                if (!g_req_valid) begin
                    state_nxt = ST_IDLE;
                end else if (s_req_ready) begin
                    ctr_load  = 1'b1;
                    state_nxt = s_req_we ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: begin
                s_write_valid = g_write_valid;
                ctr_beat      = g_write_valid;
                if (g_write_valid && ctr_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RDATA: begin
                s_read_ack    = g_read_ack;
                m0_read_valid = s_read_valid && !grant;
                m1_read_valid = s_read_valid && grant;
                ctr_beat      = s_read_valid && g_read_ack;
                if (ctr_beat && ctr_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    req_arb_beat_ctr #(.LW(LW)) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (s_req_len),
        .beat     (ctr_beat),
        .last     (ctr_last)
    );

endmodule
